// File: rtl/ace_pkg.sv
// ----------------------------------------------------------------------------
// ace_pkg
// Shared definitions for the ACE snoop initiator:
//   - AR / AW snoop request encodings accepted from the shareability decoder
//   - AC snoop opcodes broadcast to the snooped masters
//   - CR response struct and its bit positions
//   - FSM state encoding of the snoop initiator
// No ports (package).
// ----------------------------------------------------------------------------
package ace_pkg;

    // AR snoop encodings (4 bits)
    localparam logic [3:0] AR_READ_ONCE             = 4'b0000;
    localparam logic [3:0] AR_READ_SHARED           = 4'b0001;
    localparam logic [3:0] AR_READ_CLEAN            = 4'b0010;
    localparam logic [3:0] AR_READ_NOT_SHARED_DIRTY = 4'b0011;
    localparam logic [3:0] AR_READ_UNIQUE           = 4'b0111;
    localparam logic [3:0] AR_CLEAN_SHARED          = 4'b1000;
    localparam logic [3:0] AR_CLEAN_INVALID         = 4'b1001;
    localparam logic [3:0] AR_CLEAN_UNIQUE          = 4'b1011;
    localparam logic [3:0] AR_MAKE_UNIQUE           = 4'b1100;
    localparam logic [3:0] AR_MAKE_INVALID          = 4'b1101;

    // AW snoop encodings (3 bits, arrive zero-extended to 4)
    localparam logic [2:0] AW_WRITE_UNIQUE          = 3'b000;
    localparam logic [2:0] AW_WRITE_LINE_UNIQUE     = 3'b001;

    // AC snoop opcodes
    localparam logic [3:0] AC_READ_ONCE             = 4'b0000;
    localparam logic [3:0] AC_READ_SHARED           = 4'b0001;
    localparam logic [3:0] AC_READ_CLEAN            = 4'b0010;
    localparam logic [3:0] AC_READ_NOT_SHARED_DIRTY = 4'b0011;
    localparam logic [3:0] AC_READ_UNIQUE           = 4'b0111;
    localparam logic [3:0] AC_CLEAN_SHARED          = 4'b1000;
    localparam logic [3:0] AC_CLEAN_INVALID         = 4'b1001;
    localparam logic [3:0] AC_MAKE_INVALID          = 4'b1101;

    // CR response layout
    localparam int CR_W                = 5;
    localparam int CR_DATA_TRANSFER    = 0;
    localparam int CR_ERROR            = 1;
    localparam int CR_PASS_DIRTY       = 2;
    localparam int CR_IS_SHARED        = 3;
    localparam int CR_WAS_UNIQUE       = 4;

    typedef struct packed {
        logic was_unique;     // bit 4
        logic is_shared;      // bit 3
        logic pass_dirty;     // bit 2
        logic error;          // bit 1
        logic data_transfer;  // bit 0
    } cr_resp_t;

    // Aggregated response returned when the request opcode cannot be snooped
    localparam logic [CR_W-1:0] CR_RESP_UNSUPPORTED = 5'b00010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_RESP  = 2'd2
    } snp_state_e;

endpackage

// File: rtl/ace_snoop_map.sv
// ----------------------------------------------------------------------------
// ace_snoop_map
// Combinational translation of an incoming AR/AW snoop request into the AC
// snoop opcode broadcast to the snooped masters.
// Ports:
//   i_is_aw        1 = AW request (3-bit snoop, zero-extended), 0 = AR request
//   i_snoop        request snoop field
//   o_ac_snoop     mapped AC opcode (0 when unsupported)
//   o_unsupported  request opcode has no AC equivalent
// ----------------------------------------------------------------------------
module ace_snoop_map
    import ace_pkg::*;
(
    input  logic       i_is_aw,
    input  logic [3:0] i_snoop,
    output logic [3:0] o_ac_snoop,
    output logic       o_unsupported
);

    always_comb begin
        o_ac_snoop    = AC_READ_ONCE;
        o_unsupported = 1'b0;
        if (i_is_aw) begin
            // Bit 3 must be zero: anything above the 3-bit AW range is rejected.
            case (i_snoop)
                {1'b0, AW_WRITE_UNIQUE}:      o_ac_snoop = AC_CLEAN_INVALID;
                {1'b0, AW_WRITE_LINE_UNIQUE}: o_ac_snoop = AC_MAKE_INVALID;
                default:                      o_unsupported = 1'b1;
            endcase
        end else begin
            case (i_snoop)
                AR_READ_ONCE:             o_ac_snoop = AC_READ_ONCE;
                AR_READ_SHARED:           o_ac_snoop = AC_READ_SHARED;
                AR_READ_CLEAN:            o_ac_snoop = AC_READ_CLEAN;
                AR_READ_NOT_SHARED_DIRTY: o_ac_snoop = AC_READ_NOT_SHARED_DIRTY;
                AR_READ_UNIQUE:           o_ac_snoop = AC_READ_UNIQUE;
                AR_CLEAN_SHARED:          o_ac_snoop = AC_CLEAN_SHARED;
                AR_CLEAN_INVALID:         o_ac_snoop = AC_CLEAN_INVALID;
                AR_MAKE_INVALID:          o_ac_snoop = AC_MAKE_INVALID;
                // Unique-gaining requests only need the other copies gone.
                AR_CLEAN_UNIQUE:          o_ac_snoop = AC_CLEAN_INVALID;
                AR_MAKE_UNIQUE:           o_ac_snoop = AC_MAKE_INVALID;
                default:                  o_unsupported = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ace_snoop_issue.sv
// ----------------------------------------------------------------------------
// ace_snoop_issue
// CCU-side snoop initiator. Accepts one shareable AR/AW request, broadcasts
// the mapped AC snoop to every snooped master except the initiator, gathers
// one CR response per snooper and returns a single aggregated response.
// Exactly one transaction is in flight at a time.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_*                  request channel from the shareability decoder
//   ac_valid_o/ac_ready_i  per-snooper AC handshake; ac_addr/snoop/prot shared
//   cr_valid_i/cr_ready_o  per-snooper CR handshake; cr_resp_i 5 bits each
//   resp_valid_o/ready_i   aggregated response handshake
//   resp_o                 OR of accepted CR responses (error bit forced for
//                          unsupported opcodes)
//   resp_src_o             lowest snooper index that returned DataTransfer
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a valid, once raised, stays high with stable
// payload until that transfer; ready may depend on state but never on the
// same channel's valid.
// ----------------------------------------------------------------------------
module ace_snoop_issue
    import ace_pkg::*;
#(
    parameter int NumSnp    = 2,
    parameter int AddrWidth = 64,
    parameter int IdxWidth  = (NumSnp > 1) ? $clog2(NumSnp) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_is_aw_i,
    input  logic [3:0]               req_snoop_i,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [2:0]               req_prot_i,
    input  logic [IdxWidth-1:0]      req_init_i,

    output logic [NumSnp-1:0]        ac_valid_o,
    input  logic [NumSnp-1:0]        ac_ready_i,
    output logic [AddrWidth-1:0]     ac_addr_o,
    output logic [3:0]               ac_snoop_o,
    output logic [2:0]               ac_prot_o,

    input  logic [NumSnp-1:0]        cr_valid_i,
    output logic [NumSnp-1:0]        cr_ready_o,
    input  logic [NumSnp*CR_W-1:0]   cr_resp_i,

    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [CR_W-1:0]          resp_o,
    output logic [IdxWidth-1:0]      resp_src_o
);

    snp_state_e             r_state;
    snp_state_e             w_state_nxt;

    logic [AddrWidth-1:0]   r_addr;
    logic [2:0]             r_prot;
    logic [3:0]             r_snoop;
    logic [NumSnp-1:0]      r_ac_pend;
    logic [NumSnp-1:0]      r_cr_pend;
    logic [CR_W-1:0]        r_acc;
    logic [IdxWidth-1:0]    r_src;
    logic                   r_src_found;

    logic                   w_req_hs;
    logic [3:0]             w_map_snoop;
    logic                   w_map_unsup;
    logic [NumSnp-1:0]      w_init_mask;
    logic [NumSnp-1:0]      w_ac_hs;
    logic [NumSnp-1:0]      w_cr_hs;
    logic [NumSnp-1:0]      w_ac_pend_nxt;
    logic [NumSnp-1:0]      w_cr_pend_nxt;
    logic [CR_W-1:0]        w_cr_or;
    logic                   w_src_hit;
    logic [IdxWidth-1:0]    w_src_idx;
    cr_resp_t               w_cr_one;

    ace_snoop_map u_map (
        .i_is_aw       (req_is_aw_i),
        .i_snoop       (req_snoop_i),
        .o_ac_snoop    (w_map_snoop),
        .o_unsupported (w_map_unsup)
    );

    // Every snooper except the initiator. An out-of-range initiator index
    // simply excludes nobody.
    always_comb begin
        w_init_mask = '0;
        for (int i = 0; i < NumSnp; i++) begin
            w_init_mask[i] = (req_init_i != IdxWidth'(i));
        end
    end

    assign w_req_hs      = req_valid_i & req_ready_o;
    assign w_ac_hs       = ac_valid_o & ac_ready_i;
    assign w_cr_hs       = cr_valid_i & cr_ready_o;
    assign w_ac_pend_nxt = r_ac_pend & ~w_ac_hs;
    assign w_cr_pend_nxt = r_cr_pend & ~w_cr_hs;

    // Merge of this cycle's accepted CRs. Scanning downward leaves the lowest
    // DataTransfer index in w_src_idx.
    always_comb begin
        w_cr_or   = '0;
        w_src_hit = 1'b0;
        w_src_idx = '0;
        w_cr_one  = '0;
        for (int i = NumSnp - 1; i >= 0; i--) begin
            w_cr_one = cr_resp_t'(cr_resp_i[i*CR_W +: CR_W]);
            if (w_cr_hs[i]) begin
                w_cr_or = w_cr_or | w_cr_one;
                if (w_cr_one.data_transfer) begin
                    w_src_hit = 1'b1;
                    w_src_idx = IdxWidth'(i);
                end
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        ac_valid_o   = '0;
        cr_ready_o   = '0;
        resp_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (w_req_hs) begin
                    if (w_map_unsup || (w_init_mask == '0)) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_SNOOP;
                    end
                end
            end
            ST_SNOOP: begin
                ac_valid_o = r_ac_pend;
                // A snooper's CR is only taken once its own AC has gone out.
                cr_ready_o = r_cr_pend & ~r_ac_pend;
                if ((w_ac_pend_nxt == '0) && (w_cr_pend_nxt == '0)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_prot      <= '0;
            r_snoop     <= '0;
            r_ac_pend   <= '0;
            r_cr_pend   <= '0;
            r_acc       <= '0;
            r_src       <= '0;
            r_src_found <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_addr      <= req_addr_i;
                        r_prot      <= req_prot_i;
                        r_snoop     <= w_map_snoop;
                        r_src       <= '0;
                        r_src_found <= 1'b0;
                        if (w_map_unsup) begin
                            r_ac_pend <= '0;
                            r_cr_pend <= '0;
                            r_acc     <= CR_RESP_UNSUPPORTED;
                        end else begin
                            r_ac_pend <= w_init_mask;
                            r_cr_pend <= w_init_mask;
                            r_acc     <= '0;
                        end
                    end
                end
                ST_SNOOP: begin
                    r_ac_pend <= w_ac_pend_nxt;
                    r_cr_pend <= w_cr_pend_nxt;
                    r_acc     <= r_acc | w_cr_or;
                    // Keep the lowest data-carrying index even if a higher
                    // one answered first.
                    if (w_src_hit && (!r_src_found || (w_src_idx < r_src))) begin
                        r_src       <= w_src_idx;
                        r_src_found <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ac_addr_o  = r_addr;
    assign ac_snoop_o = r_snoop;
    assign ac_prot_o  = r_prot;
    assign resp_o     = r_acc;
    assign resp_src_o = r_src;

endmodule
